local_predictor_table: RTL and testbench

- Pattern history table that sits directly downstream of the ghr block. It consumes the 2-bit LocalSrc history pattern and combines it with PC index bits to select one 2-bit saturating counter.
- Provides a combinational taken/untaken prediction for the Fetch-stage PC.
- Trains the selected counter with the resolved branch outcome from Execute.
- Together with ghr it forms the two-level branch predictor feeding the branch target/PC-select logic.

---
 rtl/local_predictor_table.sv | 60 ++++++
 tb/tb_local_predictor_table.sv | 132 +++++++++++++
 2 files changed

// File: rtl/local_predictor_table.sv
// Pattern history table of 2-bit saturating counters, banked by the LocalSrc
// history from ghr and indexed by PC word bits; combinational lookup, clocked training.
module local_predictor_table #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallE,
  input  logic [1:0]  LocalSrc,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        BranchOpEb0,
  input  logic        PCSrcResE,
  output logic        PredTakenF,
  output logic [1:0]  PredStateF
);

  localparam int AW      = INDEX_WIDTH + 2;
  localparam int ENTRIES = 1 << AW;

  logic [1:0]    counters [ENTRIES];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [1:0]    cur_state;
  logic [1:0]    next_state;
  logic          train;

  assign rd_idx = {LocalSrc, PCF[INDEX_WIDTH+1:2]};
  assign wr_idx = {LocalSrc, PCE[INDEX_WIDTH+1:2]};
  assign train  = BranchOpEb0 && !stallE;

  // Byte offset and PC bits above the index only alias entries; they are never decoded.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[31:INDEX_WIDTH+2], PCF[1:0],
                            PCE[31:INDEX_WIDTH+2], PCE[1:0]};

  // Saturating step; clamp at the ends so a strong counter never flips polarity.
  always_comb begin
    cur_state  = counters[wr_idx];
    next_state = cur_state;
    if (PCSrcResE) begin
      if (cur_state != 2'b11) next_state = cur_state + 2'b01;
    end else begin
      if (cur_state != 2'b00) next_state = cur_state - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= 2'b01;
    end else if (train) begin
      counters[wr_idx] <= next_state;
    end
  end

  // No write bypass: a same-cycle collision reads the pre-update counter.
  assign PredStateF = counters[rd_idx];
  assign PredTakenF = PredStateF[1];

endmodule

// File: tb/tb_local_predictor_table.sv
// Scoreboard bench for local_predictor_table: the stimulus queues expected counter
// values per cycle and a negedge monitor pops and compares them.
module tb_local_predictor_table;

  logic        clk;
  logic        reset;
  logic        stallE;
  logic [1:0]  LocalSrc;
  logic [31:0] PCF;
  logic [31:0] PCE;
  logic        BranchOpEb0;
  logic        PCSrcResE;
  logic        PredTakenF;
  logic [1:0]  PredStateF;

  typedef struct {
    logic [1:0] state;
    logic       taken;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  local_predictor_table #(.INDEX_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .stallE(stallE), .LocalSrc(LocalSrc),
    .PCF(PCF), .PCE(PCE), .BranchOpEb0(BranchOpEb0), .PCSrcResE(PCSrcResE),
    .PredTakenF(PredTakenF), .PredStateF(PredStateF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge; optionally queue the expected lookup.
  task automatic applyStimulus(input logic rst, input logic [1:0] ls,
                               input logic [31:0] pcf, input logic [31:0] pce,
                               input logic br, input logic res, input logic stall,
                               input logic chk, input logic [1:0] exp_state,
                               input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; LocalSrc = ls; PCF = pcf; PCE = pce;
    BranchOpEb0 = br; PCSrcResE = res; stallE = stall;
    if (chk) begin
      e.state = exp_state;
      e.taken = exp_state[1];
      e.name  = name;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (PredStateF !== e.state) begin
      errors++;
      $display("[TB] FAIL %s PredStateF got %b want %b", e.name, PredStateF, e.state);
    end
    checks++;
    if (PredTakenF !== e.taken) begin
      errors++;
      $display("[TB] FAIL %s PredTakenF got %b want %b", e.name, PredTakenF, e.taken);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    logic [31:0] sweep_pc [3];
    logic [1:0]  exp_sat  [8];
    sweep_pc = '{32'h0, 32'h4, 32'h3FC};
    exp_sat  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};

    reset = 1'b1; stallE = 1'b0; LocalSrc = 2'b00; PCF = '0; PCE = '0;
    BranchOpEb0 = 1'b0; PCSrcResE = 1'b0;

    applyStimulus(1, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00, "reset_edge");

    // Reset sweep across all banks
    for (int ls = 0; ls < 4; ls++)
      for (int p = 0; p < 3; p++)
        applyStimulus(0, 2'(ls), sweep_pc[p], 32'h0, 0, 0, 0, 1, 2'b01, "reset_sweep");

    // Saturating up then down on LocalSrc=01, PC 0x40
    for (int k = 0; k < 8; k++)
      applyStimulus(0, 2'd1, 32'h40, 32'h40, 1, (k < 4), 0, 1, exp_sat[k], "saturate");
    applyStimulus(0, 2'd1, 32'h40, 32'h40, 0, 0, 0, 1, 2'b00, "saturate_floor");

    // Bank isolation
    applyStimulus(0, 2'd3, 32'h80, 32'h80, 1, 1, 0, 1, 2'b01, "bank_train0");
    applyStimulus(0, 2'd3, 32'h80, 32'h80, 1, 1, 0, 1, 2'b10, "bank_train1");
    applyStimulus(0, 2'd0, 32'h80, 32'h80, 0, 0, 0, 1, 2'b01, "bank_ls00");
    applyStimulus(0, 2'd3, 32'h80, 32'h80, 0, 0, 0, 1, 2'b11, "bank_ls11");
    applyStimulus(0, 2'd1, 32'h80, 32'h80, 0, 0, 0, 1, 2'b01, "bank_ls01");
    applyStimulus(0, 2'd1, 32'h40, 32'h80, 0, 0, 0, 1, 2'b00, "bank_keep");

    // Enable and stall gating on a mid-range counter
    for (int k = 0; k < 8; k++)
      applyStimulus(0, 2'd2, 32'hC0, 32'hC0, 0, k[0], 0, 1, 2'b01, "no_branch");
    for (int k = 0; k < 8; k++)
      applyStimulus(0, 2'd2, 32'hC0, 32'hC0, 1, k[0], 1, 1, 2'b01, "stalled");
    applyStimulus(0, 2'd2, 32'hC0, 32'hC0, 0, 0, 0, 1, 2'b01, "gate_after");

    // Collision and aliasing
    applyStimulus(0, 2'd0, 32'h100, 32'h100, 1, 1, 0, 1, 2'b01, "collide_same");
    applyStimulus(0, 2'd0, 32'h100, 32'h100, 0, 0, 0, 1, 2'b10, "collide_next");
    applyStimulus(0, 2'd0, 32'h500, 32'h0, 0, 0, 0, 1, 2'b10, "alias_high");
    applyStimulus(0, 2'd0, 32'h103, 32'h0, 0, 0, 0, 1, 2'b10, "alias_low");

    // Reset priority over a simultaneous training request
    applyStimulus(1, 2'd3, 32'h80, 32'h80, 1, 1, 0, 1, 2'b11, "rst_pre");
    applyStimulus(0, 2'd3, 32'h80, 32'h80, 0, 0, 0, 1, 2'b01, "rst_target");
    applyStimulus(0, 2'd0, 32'h100, 32'h0, 0, 0, 0, 1, 2'b01, "rst_other0");
    applyStimulus(0, 2'd1, 32'h40, 32'h0, 0, 0, 0, 1, 2'b01, "rst_other1");
    applyStimulus(0, 2'd2, 32'hC0, 32'h0, 0, 0, 0, 1, 2'b01, "rst_other2");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
